// File: rtl/fir_pkg.sv
// Shared defaults and types for the inverse FIR (deconvolution) filter.
package fir_pkg;

   localparam int N_DEF   = 3;
   localparam int W_X_DEF = 4;
   localparam int W_K_DEF = 4;

   // The y width equals the fir_filter output width, so the pair can be chained directly.
   function automatic int w_y(input int w_x, input int w_k, input int n);
      return w_x + w_k + $clog2(n);
   endfunction

   localparam int W_Y_DEF = w_y(W_X_DEF, W_K_DEF, N_DEF);
   localparam int W_A_DEF = W_Y_DEF + 1;

   typedef logic signed [W_X_DEF-1:0] x_t;
   typedef logic signed [W_K_DEF-1:0] k_t;
   typedef logic signed [W_Y_DEF-1:0] y_t;
   typedef logic signed [W_A_DEF-1:0] acc_t;

   localparam k_t K_DEF [N_DEF+1] = '{k_t'(1), k_t'(1), k_t'(1), k_t'(1)};

endpackage

// File: rtl/fir_inv_history.sv
// N-deep signed shift register of past recovered samples; o_h[0] is h[1], the newest sample.
module fir_inv_history
   import fir_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_X_DEF
) (
   input  logic                i_clk,
   input  logic                i_clr,
   input  logic                i_en,
   input  logic signed [W-1:0] i_d,
   output logic signed [W-1:0] o_h [N]
);

   logic signed [W-1:0] r_h [N];

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         for (int i = 0; i < N; i++) r_h[i] <= '0;
      end else if (i_en) begin
         r_h[0] <= i_d;
         for (int i = 1; i < N; i++) r_h[i] <= r_h[i-1];
      end
   end

   assign o_h = r_h;

endmodule

// File: rtl/fir_inverse_filter.sv
// Recursive inverse FIR: x[n] = (y[n] - sum K[i]*x[n-i]) / K[0], K[0] = +/-1, 1-cycle latency.
// Optional build macro FIR_INV_SAT_EN: saturate x to W_X bits and add sticky o_ovf.
module fir_inverse_filter
   import fir_pkg::*;
#(
   parameter int N   = N_DEF,
   parameter int W_X = W_X_DEF,
   parameter int W_K = W_K_DEF,
   parameter int W_Y = w_y(W_X, W_K, N),
   parameter logic signed [W_K-1:0] K [N+1] = K_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic signed [W_Y-1:0] i_y,
   input  logic                  i_y_valid,
   output logic                  o_y_ready,
   output logic signed [W_X-1:0] o_x,
   output logic                  o_x_valid,
   input  logic                  i_x_ready
`ifdef FIR_INV_SAT_EN
   ,
   output logic                  o_ovf
`endif
);

   localparam int W_A = W_Y + 1;

   typedef logic signed [W_A-1:0] acc_l_t;
   typedef logic signed [W_X-1:0] x_l_t;

   localparam bit K0_NEG = (K[0] == -1);

   if (!((K[0] == 1) || (K[0] == -1))) begin : g_k0_check
      $error("fir_inverse_filter: K[0] must be +1 or -1");
   end

   logic   r_x_valid;
   x_l_t   r_x;
   logic   w_y_ready;
   logic   w_accept;
   logic   w_pop;
   x_l_t   w_h [N];
   acc_l_t w_mac;
   acc_l_t w_acc;
   x_l_t   w_red;

   assign w_pop     = r_x_valid && i_x_ready;
   assign w_y_ready = !i_rst && (!r_x_valid || i_x_ready);
   assign w_accept  = i_y_valid && w_y_ready;

   // One extra bit over y keeps y minus the feedback sum from wrapping.
   always_comb begin
      w_mac = acc_l_t'(i_y);
      for (int i = 1; i <= N; i++) begin
         w_mac = w_mac - acc_l_t'(K[i]) * acc_l_t'(w_h[i-1]);
      end
      w_acc = K0_NEG ? -w_mac : w_mac;
   end

`ifdef FIR_INV_SAT_EN
   localparam acc_l_t ACC_MAX = acc_l_t'((1 << (W_X-1)) - 1);
   localparam acc_l_t ACC_MIN = acc_l_t'(-(1 << (W_X-1)));
   localparam x_l_t   X_MAX   = {1'b0, {(W_X-1){1'b1}}};
   localparam x_l_t   X_MIN   = {1'b1, {(W_X-1){1'b0}}};

   logic w_sat;
   logic r_ovf;

   always_comb begin
      w_sat = 1'b0;
      w_red = w_acc[W_X-1:0];
      if (w_acc > ACC_MAX) begin
         w_sat = 1'b1;
         w_red = X_MAX;
      end else if (w_acc < ACC_MIN) begin
         w_sat = 1'b1;
         w_red = X_MIN;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ovf <= 1'b0;
      end else if (w_accept && w_sat) begin
         r_ovf <= 1'b1;
      end
   end

   assign o_ovf = r_ovf;
`else
   logic w_unused_acc_hi;

   assign w_red           = w_acc[W_X-1:0];
   assign w_unused_acc_hi = ^w_acc[W_A-1:W_X];
`endif

   // The reduced value feeds both the output and the history so they never diverge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_x       <= '0;
         r_x_valid <= 1'b0;
      end else if (w_accept) begin
         r_x       <= w_red;
         r_x_valid <= 1'b1;
      end else if (w_pop) begin
         r_x_valid <= 1'b0;
      end
   end

   fir_inv_history #(
      .N (N),
      .W (W_X)
   ) u_history (
      .i_clk (i_clk),
      .i_clr (i_rst),
      .i_en  (w_accept),
      .i_d   (w_red),
      .o_h   (w_h)
   );

   assign o_y_ready = w_y_ready;
   assign o_x       = r_x;
   assign o_x_valid = r_x_valid;

endmodule

// File: tb/tb_fir_inverse_filter.sv
// Directed bench for fir_inverse_filter with K = {1,1,1,1}; honours FIR_INV_SAT_EN.
module tb_fir_inverse_filter;

   logic              clk = 1'b0;
   logic              i_rst;
   logic signed [9:0] i_y;
   logic              i_y_valid;
   logic              o_y_ready;
   logic signed [3:0] o_x;
   logic              o_x_valid;
   logic              i_x_ready;
`ifdef FIR_INV_SAT_EN
   logic              o_ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fir_inverse_filter dut (
      .i_clk     (clk),
      .i_rst     (i_rst),
      .i_y       (i_y),
      .i_y_valid (i_y_valid),
      .o_y_ready (o_y_ready),
      .o_x       (o_x),
      .o_x_valid (o_x_valid),
      .i_x_ready (i_x_ready)
`ifdef FIR_INV_SAT_EN
      ,
      .o_ovf     (o_ovf)
`endif
   );

   task automatic reset_dut();
      @(negedge clk);
      i_rst     = 1'b1;
      i_y_valid = 1'b0;
      i_y       = '0;
      i_x_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      i_rst     = 1'b1;
      i_y_valid = 1'b0;
      i_y       = '0;
      i_x_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (o_x_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_x_valid: got %0b expected 0", o_x_valid);
      end
      n_checks++;
      if (o_x !== 4'sd0) begin
         n_fail++;
         $display("FAIL reset_x: got %0d expected 0", o_x);
      end
      n_checks++;
      if (o_y_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_y_ready: got %0b expected 0", o_y_ready);
      end
`ifdef FIR_INV_SAT_EN
      n_checks++;
      if (o_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ovf: got %0b expected 0", o_ovf);
      end
`endif
      i_rst = 1'b0;
      #1;
      n_checks++;
      if (o_y_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_y_ready: got %0b expected 1", o_y_ready);
      end
   endtask

   task automatic test_step();
      int ys [6] = '{1, 2, 3, 4, 4, 4};
      int xs [6] = '{1, 1, 1, 1, 1, 1};
      logic signed [3:0] ex;
      reset_dut();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         i_y       = 10'(ys[i]);
         i_y_valid = 1'b1;
         if (i == 0) begin
            n_checks++;
            if (o_x_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL step_latency: x_valid got %0b expected 0 before accept", o_x_valid);
            end
         end
         @(posedge clk);
         #1;
         ex = 4'(xs[i]);
         n_checks++;
         if (o_x_valid !== 1'b1 || o_x !== ex) begin
            n_fail++;
            $display("FAIL step[%0d]: got x=%0d valid=%0b expected x=%0d valid=1", i, o_x, o_x_valid, ex);
         end
      end
      @(negedge clk);
      i_y_valid = 1'b0;
   endtask

   task automatic test_impulse();
      int ys [7] = '{3, 3, 3, 3, 0, 0, 0};
      int xs [7] = '{3, 0, 0, 0, 0, 0, 0};
      logic signed [3:0] ex;
      reset_dut();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         i_y       = 10'(ys[i]);
         i_y_valid = 1'b1;
         @(posedge clk);
         #1;
         ex = 4'(xs[i]);
         n_checks++;
         if (o_x_valid !== 1'b1 || o_x !== ex) begin
            n_fail++;
            $display("FAIL impulse[%0d]: got x=%0d valid=%0b expected x=%0d valid=1", i, o_x, o_x_valid, ex);
         end
      end
      @(negedge clk);
      i_y_valid = 1'b0;
   endtask

   // Forward FIR (all taps 1) generates y; the DUT must hand back the original x.
   task automatic test_random_loopback();
      int xv, x1, x2, x3, yv;
      logic signed [3:0] ex;
      x1 = 0;
      x2 = 0;
      x3 = 0;
      reset_dut();
      for (int i = 0; i < 24; i++) begin
         xv = int'($urandom_range(15)) - 8;
         yv = xv + x1 + x2 + x3;
         x3 = x2;
         x2 = x1;
         x1 = xv;
         @(negedge clk);
         i_y       = 10'(yv);
         i_y_valid = 1'b1;
         @(posedge clk);
         #1;
         ex = 4'(xv);
         n_checks++;
         if (o_x_valid !== 1'b1 || o_x !== ex) begin
            n_fail++;
            $display("FAIL loopback[%0d]: got x=%0d valid=%0b expected x=%0d valid=1", i, o_x, o_x_valid, ex);
         end
      end
      @(negedge clk);
      i_y_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      reset_dut();
      i_x_ready = 1'b0;
      i_y       = 10'sd2;
      i_y_valid = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (o_x_valid !== 1'b1 || o_x !== 4'sd2) begin
         n_fail++;
         $display("FAIL bp_first: got x=%0d valid=%0b expected x=2 valid=1", o_x, o_x_valid);
      end
      @(negedge clk);
      i_y = 10'sd5;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (o_y_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_y_ready[%0d]: got %0b expected 0", k, o_y_ready);
         end
         @(posedge clk);
         #1;
         n_checks++;
         if (o_x_valid !== 1'b1 || o_x !== 4'sd2) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got x=%0d valid=%0b expected x=2 valid=1", k, o_x, o_x_valid);
         end
         @(negedge clk);
      end
      i_x_ready = 1'b1;
      #1;
      n_checks++;
      if (o_y_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_ready: got %0b expected 1", o_y_ready);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (o_x_valid !== 1'b1 || o_x !== 4'sd3) begin
         n_fail++;
         $display("FAIL bp_resume: got x=%0d valid=%0b expected x=3 valid=1", o_x, o_x_valid);
      end
      @(negedge clk);
      i_y_valid = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (o_x_valid !== 1'b0 || o_x !== 4'sd3) begin
         n_fail++;
         $display("FAIL bp_drain: got x=%0d valid=%0b expected x=3 valid=0", o_x, o_x_valid);
      end
   endtask

   task automatic test_midstream_reset();
      int ys [2] = '{1, 2};
      reset_dut();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         i_y       = 10'(ys[i]);
         i_y_valid = 1'b1;
         @(posedge clk);
         #1;
         n_checks++;
         if (o_x_valid !== 1'b1 || o_x !== 4'sd1) begin
            n_fail++;
            $display("FAIL rst_pre[%0d]: got x=%0d valid=%0b expected x=1 valid=1", i, o_x, o_x_valid);
         end
      end
      @(negedge clk);
      i_rst = 1'b1;
      i_y   = 10'sd5;
      #1;
      n_checks++;
      if (o_y_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_y_ready: got %0b expected 0", o_y_ready);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (o_x_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_drop: got valid=%0b expected 0", o_x_valid);
      end
      @(negedge clk);
      i_rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (o_x_valid !== 1'b1 || o_x !== 4'sd5) begin
         n_fail++;
         $display("FAIL rst_fresh: got x=%0d valid=%0b expected x=5 valid=1", o_x, o_x_valid);
      end
      @(negedge clk);
      i_y_valid = 1'b0;
   endtask

   task automatic test_overflow();
      logic signed [3:0] ex0, ex1;
`ifdef FIR_INV_SAT_EN
      ex0 = 4'sd7;
      ex1 = -4'sd7;
`else
      ex0 = 4'sd4;
      ex1 = -4'sd4;
`endif
      reset_dut();
      i_y       = 10'sd20;
      i_y_valid = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (o_x_valid !== 1'b1 || o_x !== ex0) begin
         n_fail++;
         $display("FAIL ovf_x: got x=%0d valid=%0b expected x=%0d valid=1", o_x, o_x_valid, ex0);
      end
`ifdef FIR_INV_SAT_EN
      n_checks++;
      if (o_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set: got %0b expected 1", o_ovf);
      end
`endif
      @(negedge clk);
      i_y = 10'sd0;
      @(posedge clk);
      #1;
      n_checks++;
      if (o_x_valid !== 1'b1 || o_x !== ex1) begin
         n_fail++;
         $display("FAIL ovf_next_x: got x=%0d valid=%0b expected x=%0d valid=1", o_x, o_x_valid, ex1);
      end
      @(negedge clk);
      i_y_valid = 1'b0;
      @(posedge clk);
      #1;
`ifdef FIR_INV_SAT_EN
      n_checks++;
      if (o_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky: got %0b expected 1", o_ovf);
      end
`endif
      n_checks++;
      if (o_x_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_drain: got valid=%0b expected 0", o_x_valid);
      end
   endtask

   initial begin
      test_reset();
      test_step();
      test_impulse();
      test_random_loopback();
      test_backpressure();
      test_midstream_reset();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
